stream_demux_n: RTL and testbench

Parametrised, registered 1-to-N demultiplexer for data streams. It generalises the 3-bit-select, 1-bit, 8-way combinational demux to W-bit data, N channels and a valid/ready handshake. Each channel has a one-entry output register, so a stalled sink back-pressures only transfers aimed at that channel. It sits between a single producer and N independent consumers, for example a packet steering stage in front of per-channel processing.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_if.sv | 30 +++
 rtl/stream_demux_slot.sv | 55 +++++
 rtl/stream_demux_n.sv | 114 +++++++++++
 tb/tb_stream_demux_n.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux_n block.
package stream_demux_pkg;

    localparam int unsigned CNT_W = 16;

    // IDLE_ZERO encodings: hold last word, or gate dout to zero while idle
    localparam int unsigned IDLE_ZERO_HOLD = 0;
    localparam int unsigned IDLE_ZERO_GATE = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side stream signals of stream_demux_n.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 8
) ();

    localparam int unsigned SEL_W = clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     din;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [N*W-1:0]   dout;
    logic             sel_err;

    modport master (
        output in_valid, din, sel, out_ready,
        input  in_ready, out_valid, dout, sel_err
    );

    modport slave (
        input  in_valid, din, sel, out_ready,
        output in_ready, out_valid, dout, sel_err
    );

endinterface

// File: rtl/stream_demux_slot.sv
// demux_slot: one-entry output register for a single demux channel.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned IDLE_ZERO = IDLE_ZERO_GATE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         ready_i,
    input  logic [W-1:0] din_i,
    output logic         valid_o,
    output logic         drain_o,
    output logic [W-1:0] dout_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign drain_o = valid_q & ready_i;

    // A load wins over a drain: the slot refills in the cycle it empties.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = din_i;
        end else if (drain_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;

    generate
        if (IDLE_ZERO == IDLE_ZERO_GATE) begin : g_gate
            assign dout_o = valid_q ? data_q : '0;
        end else begin : g_hold
            assign dout_o = data_q;
        end
    endgenerate

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with per-channel output slots.
// Optional per-channel drain counters when STREAM_DEMUX_CNT_EN is defined.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned N         = 8,
    parameter int unsigned SEL_W     = clog2(N),
    parameter int unsigned IDLE_ZERO = IDLE_ZERO_GATE
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef STREAM_DEMUX_CNT_EN
    input  logic                 clr_cnt_i,
    output logic [N*CNT_W-1:0]   cnt_o,
`endif
    stream_demux_if.slave        bus
);

    logic [N-1:0] sel_hit;
    logic [N-1:0] load;
    logic [N-1:0] drain;
    logic [N-1:0] valid;
    logic [W-1:0] slot_dout [N];
    logic         in_ready;
    logic         xfer;
    logic         sel_err_q, sel_err_d;

    // An out-of-range select matches no channel, leaving in_ready at 1 (sink-drop).
    always_comb begin
        sel_hit  = '0;
        in_ready = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
                in_ready   = !valid[k] | bus.out_ready[k];
            end
        end
    end

    assign xfer      = bus.in_valid & in_ready;
    assign load      = sel_hit & {N{xfer}};
    assign sel_err_d = xfer & ~(|sel_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_slot
            demux_slot #(
                .W         (W),
                .IDLE_ZERO (IDLE_ZERO)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (load[k]),
                .ready_i (bus.out_ready[k]),
                .din_i   (bus.din),
                .valid_o (valid[k]),
                .drain_o (drain[k]),
                .dout_o  (slot_dout[k])
            );
        end
    endgenerate

    always_comb begin
        bus.dout = '0;
        for (int unsigned k = 0; k < N; k++) begin
            bus.dout[k*W +: W] = slot_dout[k];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.sel_err   = sel_err_q;

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    // Clear beats a same-cycle increment; increments stop at all-ones.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_cnt_i) begin
                cnt_d[k] = '0;
            end else if (drain[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) cnt_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Self-checking bench for stream_demux_n (N=6, W=8) against a per-channel queue model.
module tb_stream_demux_n;

    localparam int N     = 6;
    localparam int W     = 8;
    localparam int SEL_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_demux_if #(.W(W), .N(N)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
    logic            clr_cnt = 1'b0;
    logic [N*16-1:0] cnt;
`endif

    stream_demux_n #(
        .W         (W),
        .N         (N),
        .IDLE_ZERO (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef STREAM_DEMUX_CNT_EN
        .clr_cnt_i (clr_cnt),
        .cnt_o     (cnt),
`endif
        .bus       (bus)
    );

    property p_hold;
        @(posedge clk) disable iff (!rst_n)
            (bus.in_valid && !bus.in_ready) |=> (bus.in_valid && $stable(bus.din) && $stable(bus.sel));
    endproperty
    a_hold: assert property (p_hold) else $error("producer hold rule broken by stimulus");

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words accepted per channel and not yet drained.
    logic [W-1:0] mq [N][$];
    logic         exp_err;
    int           cnt_m [N];
    logic         last_xfer;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_valid();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_dout();
        logic [N*W-1:0] d;
        d = '0;
        for (int k = 0; k < N; k++) if (mq[k].size() != 0) d[k*W +: W] = mq[k][0];
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            cnt_m[k] = 0;
        end
        exp_err = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", bus.out_valid, exp_valid());
        check_eq("dout", bus.dout, exp_dout());
        check_eq("sel_err", bus.sel_err, exp_err);
`ifdef STREAM_DEMUX_CNT_EN
        for (int k = 0; k < N; k++) check_eq("cnt", cnt[k*16 +: 16], cnt_m[k]);
`endif
    endtask

    // One clock: drive, check in_ready, take the edge, advance model, check outputs.
    task automatic cycle(input logic v, input logic [SEL_W-1:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] r);
        logic         exp_rdy;
        logic         xfer;
        logic [N-1:0] drn;
        logic         clr;
        int           si;
        bus.in_valid  = v;
        bus.sel       = s;
        bus.din       = d;
        bus.out_ready = r;
        #1;
        si = int'(s);
        if (si < N) exp_rdy = (mq[si].size() == 0) || r[si];
        else        exp_rdy = 1'b1;
        check_eq("in_ready", bus.in_ready, exp_rdy);
        xfer = v && exp_rdy;
        for (int k = 0; k < N; k++) drn[k] = (mq[k].size() != 0) && r[k];
`ifdef STREAM_DEMUX_CNT_EN
        clr = clr_cnt;
`else
        clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (drn[k]) void'(mq[k].pop_front());
            if (clr) cnt_m[k] = 0;
            else if (drn[k] && cnt_m[k] < 65535) cnt_m[k]++;
        end
        if (xfer && si < N) mq[si].push_back(d);
        exp_err   = xfer && (si >= N);
        last_xfer = xfer;
        check_outputs();
    endtask

    initial begin
        logic [N-1:0]     all_rdy;
        logic [N-1:0]     r2;
        logic             v;
        logic [SEL_W-1:0] s;
        logic [W-1:0]     d;
        int               acc;

        all_rdy = '1;
        model_reset();
        last_xfer     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.din       = '0;
        bus.out_ready = '0;

        // Reset state
        #12;
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Single word to ch3
        cycle(1'b1, 3'd3, 8'hA5, all_rdy);
        check_eq("tp1_ov", bus.out_valid, 6'b001000);
        check_eq("tp1_ch3", bus.dout[3*W +: W], 8'hA5);
        cycle(1'b0, 3'd0, 8'h00, all_rdy);

        // Back-pressure on ch2 must not block ch5
        r2 = 6'b111011;
        cycle(1'b1, 3'd2, 8'h11, r2);
        cycle(1'b0, 3'd2, 8'h22, r2);
        check_eq("tp2_stall", bus.in_ready, 1'b0);
        cycle(1'b1, 3'd5, 8'h33, r2);
        check_eq("tp2_ch5", bus.dout[5*W +: W], 8'h33);
        cycle(1'b1, 3'd2, 8'h22, all_rdy);
        check_eq("tp2_ch2", bus.dout[2*W +: W], 8'h22);
        cycle(1'b0, 3'd0, 8'h00, all_rdy);

        // Full-rate streaming on ch4
        acc = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 3'd4, W'(i), all_rdy);
            if (last_xfer) acc++;
        end
        check_eq("stream_acc", acc, 16);

        // Out-of-range selects, single then back-to-back
        cycle(1'b1, 3'd7, 8'hFF, all_rdy);
        check_eq("bad_err", bus.sel_err, 1'b1);
        check_eq("bad_ov", bus.out_valid, '0);
        cycle(1'b0, 3'd0, 8'h00, all_rdy);
        cycle(1'b1, 3'd6, 8'hFE, all_rdy);
        cycle(1'b1, 3'd7, 8'hFD, all_rdy);
        cycle(1'b0, 3'd0, 8'h00, all_rdy);

        // Asynchronous reset while ch1 and ch4 hold words
        cycle(1'b1, 3'd1, 8'h41, '0);
        cycle(1'b1, 3'd4, 8'h44, '0);
        check_eq("pre_rst_ov", bus.out_valid, 6'b010010);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ov", bus.out_valid, '0);
        check_eq("rst_dout", bus.dout, '0);
        model_reset();
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 3'd1, 8'h5A, all_rdy);
        check_eq("post_rst_ch1", bus.dout[1*W +: W], 8'h5A);

        // Randomised traffic with producer hold and consumers dropping ready freely
        v = 1'b0; s = '0; d = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!(v && !last_xfer)) begin
                v = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 9) == 0) ? SEL_W'($urandom_range(6, 7))
                                                : SEL_W'($urandom_range(0, 5));
                d = W'($urandom);
            end
`ifdef STREAM_DEMUX_CNT_EN
            clr_cnt = ($urandom_range(0, 63) == 0);
`endif
            cycle(v, s, d, N'($urandom | $urandom));
        end
        cycle(1'b0, 3'd0, 8'h00, all_rdy);

`ifdef STREAM_DEMUX_CNT_EN
        // Counter: basic count, saturation, clear beating a drain
        clr_cnt = 1'b1;
        cycle(1'b0, 3'd0, 8'h00, all_rdy);
        clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, W'(i), all_rdy);
        cycle(1'b0, 3'd0, 8'h00, all_rdy);
        check_eq("cnt_three", cnt[15:0], 16'd3);
        for (int i = 0; i < 65534; i++) cycle(1'b1, 3'd0, W'(i), all_rdy);
        cycle(1'b0, 3'd0, 8'h00, all_rdy);
        check_eq("cnt_sat", cnt[15:0], 16'hFFFF);
        cycle(1'b1, 3'd0, 8'h77, all_rdy);
        clr_cnt = 1'b1;
        cycle(1'b0, 3'd0, 8'h00, all_rdy);
        clr_cnt = 1'b0;
        check_eq("cnt_clr", cnt[15:0], 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
